// File: rtl/led_breathe.sv
// PWM LED stage that ramps brightness linearly on each synchronised level change.
// Latency: level_i to state change is 3 clk_i edges; led_o lags duty/pwm compare by 1 cycle.
module led_breathe #(
    parameter int FREQ     = 25000000,
    parameter int RAMP_MS  = 250,
    parameter int PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                level_i,
    output logic                led_o,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                busy_o
);

    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - PWM_BITS'(1);
    localparam logic [63:0] STEP_RAW = ((64'(FREQ) / 64'd1000) * 64'(RAMP_MS))
                                       / ((64'd1 << PWM_BITS) - 64'd1);
    localparam logic [63:0] STEP_DIV = (STEP_RAW == 64'd0) ? 64'd1 : STEP_RAW;
    localparam int          PRE_W    = $clog2(STEP_DIV + 64'd1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 64'd1);

    typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_led;
    logic                r_busy;
    logic                w_tick;

    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= level_i;
            r_sync2 <= r_sync1;
        end
    end

    // The synchronised level is checked before the step tick so a reversal never costs an extra step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_OFF;
            r_pre   <= '0;
            r_duty  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_duty <= '0;
                    r_pre  <= '0;
                    if (r_sync2) begin
                        r_state <= S_UP;
                        r_busy  <= 1'b1;
                    end
                end
                S_UP: begin
                    if (!r_sync2) begin
                        r_state <= S_DOWN;
                        r_pre   <= '0;
                    end else if (r_duty == MAX) begin
                        r_state <= S_ON;
                        r_pre   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_pre  <= '0;
                        r_duty <= r_duty + 1'b1;
                        if (r_duty == MAX_M1) begin
                            r_state <= S_ON;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                S_ON: begin
                    r_duty <= MAX;
                    r_pre  <= '0;
                    if (!r_sync2) begin
                        r_state <= S_DOWN;
                        r_busy  <= 1'b1;
                    end
                end
                S_DOWN: begin
                    if (r_sync2) begin
                        r_state <= S_UP;
                        r_pre   <= '0;
                    end else if (r_duty == '0) begin
                        r_state <= S_OFF;
                        r_pre   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_pre  <= '0;
                        r_duty <= r_duty - 1'b1;
                        if (r_duty == PWM_BITS'(1)) begin
                            r_state <= S_OFF;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_OFF;
                    r_pre   <= '0;
                    r_duty  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pwm_cnt <= '0;
            r_led     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_led     <= (r_duty == MAX) || (r_pwm_cnt < r_duty);
        end
    end

    assign led_o  = r_led;
    assign duty_o = r_duty;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with MAX=15 and a 2-cycle duty step.
module tb_led_breathe;

    logic       clk_i   = 1'b0;
    logic       rst_ni  = 1'b0;
    logic       level_i = 1'b0;
    logic       led_o;
    logic [3:0] duty_o;
    logic       busy_o;

    int n_checks  = 0;
    int n_fail    = 0;
    int ecnt      = 0;
    int pwm_errs  = 0;
    int prev_duty = 0;
    int prev_cnt  = 0;

    led_breathe #(
        .FREQ     (30000),
        .RAMP_MS  (1),
        .PWM_BITS (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (level_i),
        .led_o   (led_o),
        .duty_o  (duty_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1ns later; a reference PWM compare runs while out of reset.
    task automatic tick();
        int exp_led;
        @(posedge clk_i);
        #1;
        if (rst_ni) begin
            ecnt++;
            exp_led = (prev_duty == 15 || prev_cnt < prev_duty) ? 1 : 0;
            if (int'(led_o) != exp_led) pwm_errs++;
            prev_duty = int'(duty_o);
            prev_cnt  = ecnt % 16;
        end
    endtask

    task automatic release_rst();
        rst_ni    = 1'b1;
        ecnt      = 0;
        prev_duty = 0;
        prev_cnt  = 0;
    endtask

    task automatic do_reset(input logic lvl);
        rst_ni  = 1'b0;
        level_i = lvl;
        tick();
        tick();
        release_rst();
    endtask

    task automatic wait_duty(input string tag, input int target);
        int found;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (int'(duty_o) == target) found = 1;
            else tick();
        end
        check(tag, found, 1);
    endtask

    initial begin
        int ones;
        int errs;
        int exp_d;
        int maxd;
        int busy_g3;

        // Reset held with level high
        level_i = 1'b1;
        tick(); tick(); tick();
        check("rst_led", int'(led_o), 0);
        check("rst_duty", int'(duty_o), 0);
        check("rst_busy", int'(busy_o), 0);
        release_rst();
        tick(); tick();
        check("busy_edge2", int'(busy_o), 0);
        tick();
        check("busy_edge3", int'(busy_o), 1);

        // OFF: LED dark
        do_reset(1'b0);
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            ones += int'(led_o);
        end
        check("off_led_ones", ones, 0);
        check("off_busy", int'(busy_o), 0);

        // Full ramp up
        level_i = 1'b1;
        tick(); tick();
        check("ramp_busy_e2", int'(busy_o), 0);
        tick();
        check("ramp_busy_e3", int'(busy_o), 1);
        check("ramp_duty_e3", int'(duty_o), 0);
        errs = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (int'(duty_o) != n / 2) errs++;
            if (int'(busy_o) != ((n < 30) ? 1 : 0)) errs++;
        end
        check("ramp_step_errs", errs, 0);
        check("ramp_end_duty", int'(duty_o), 15);
        check("ramp_end_busy", int'(busy_o), 0);
        tick();
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            ones += int'(led_o);
        end
        check("on_led_ones", ones, 64);
        check("on_duty", int'(duty_o), 15);

        // Reversal at duty 7 during UP
        do_reset(1'b0);
        tick();
        level_i = 1'b1;
        wait_duty("rev_reach7", 7);
        level_i = 1'b0;
        errs = 0;
        maxd = 0;
        for (int m = 1; m <= 22; m++) begin
            tick();
            if (m == 1)      exp_d = 7;
            else if (m == 2) exp_d = 8;
            else             exp_d = (8 - (m - 3) / 2 < 0) ? 0 : 8 - (m - 3) / 2;
            if (int'(duty_o) != exp_d) errs++;
            if (int'(busy_o) != ((m < 19) ? 1 : 0)) errs++;
            if (int'(duty_o) > maxd) maxd = int'(duty_o);
        end
        check("rev_step_errs", errs, 0);
        check("rev_max_duty", maxd, 8);
        check("rev_end_duty", int'(duty_o), 0);
        check("rev_end_busy", int'(busy_o), 0);

        // One-cycle pulse from OFF
        level_i = 1'b1;
        tick();
        level_i = 1'b0;
        maxd = 0;
        busy_g3 = 0;
        for (int g = 2; g <= 10; g++) begin
            tick();
            if (g == 2) check("pulse_busy_g2", int'(busy_o), 0);
            if (g == 3) busy_g3 = int'(busy_o);
            if (int'(duty_o) > maxd) maxd = int'(duty_o);
        end
        check("pulse_busy_g3", busy_g3, 1);
        check("pulse_max_le1", (maxd <= 1) ? 1 : 0, 1);
        check("pulse_end_duty", int'(duty_o), 0);
        check("pulse_end_busy", int'(busy_o), 0);

        check("pwm_model_errs", pwm_errs, 0);

        // Asynchronous reset mid-ramp, between edges
        level_i = 1'b1;
        wait_duty("arst_reach9", 9);
        check("arst_pre_busy", int'(busy_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_led", int'(led_o), 0);
        check("arst_duty", int'(duty_o), 0);
        check("arst_busy", int'(busy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
